// File: rtl/poss_seq_pkg.sv
// Shared types and helpers for the power-on self-set sequencer.
// State encoding, end-marker test and default write timeout.
package poss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    WRITE,
    HOLDOFF,
    DONE,
    ERR
  } poss_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Reduction-AND over the low w bits of a zero-extended address.
  function automatic logic is_end_mark(
    input logic [63:0] addr,
    input int          w
  );
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (addr & m) == m;
  endfunction

endpackage

// File: rtl/poss_seq_if.sv
// Table-read and register-write bus between the sequencer
// and the module's internal register space.
interface poss_seq_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int N_ENTRIES = 32
);
  localparam int IDX_W =
    (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  logic                     tbl_rd;
  logic [IDX_W-1:0]         tbl_addr;
  logic [ADDR_W+DATA_W-1:0] tbl_rdata;
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ack;

  modport master (
    output tbl_rd, tbl_addr,
    output wr_req, wr_addr, wr_data,
    input  tbl_rdata, wr_ack
  );

  modport slave (
    input  tbl_rd, tbl_addr,
    input  wr_req, wr_addr, wr_data,
    output tbl_rdata, wr_ack
  );
endinterface

// File: rtl/poss_start_sync.sv
// Two-flop synchroniser plus rising-edge detect for
// asynchronous slow-control pulses.
module poss_start_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_out
);
  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign edge_out = r_s2 & ~r_s3;
endmodule

// File: rtl/poss_seq.sv
// Power-on self-set sequencer: walks an {addr,data} table
// and issues each entry as a req/ack write with retry.
module poss_seq
  import poss_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int N_ENTRIES = 32,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int MAX_RETRY = 3,
  localparam int IDX_W =
    (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rerun_en,
  poss_seq_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);
  localparam int TMO_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RTY_W =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  poss_state_t       r_state, w_state;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [IDX_W-1:0]  r_err_idx, w_err_idx;
  logic [TMO_W-1:0]  r_tmo, w_tmo;
  logic [RTY_W-1:0]  r_retry, w_retry;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_data, w_data;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_error, w_error;

  logic              w_start;
  logic              w_last;
  logic              w_tmo_hit;
  logic              w_mark;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  poss_start_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (start),
    .edge_out (w_start)
  );

  assign w_rd_addr =
    bus.tbl_rdata[ADDR_W+DATA_W-1 -: ADDR_W];
  assign w_rd_data = bus.tbl_rdata[DATA_W-1:0];
  assign w_mark =
    is_end_mark(64'(w_rd_addr), ADDR_W);
  assign w_last =
    (r_idx == IDX_W'(N_ENTRIES - 1));
  assign w_tmo_hit =
    (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_err_idx <= '0;
      r_tmo     <= '0;
      r_retry   <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_err_idx <= w_err_idx;
      r_tmo     <= w_tmo;
      r_retry   <= w_retry;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_error   <= w_error;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_err_idx = r_err_idx;
    w_tmo     = r_tmo;
    w_retry   = r_retry;
    w_addr    = r_addr;
    w_data    = r_data;
    w_busy    = r_busy;
    w_done    = r_done;
    w_error   = r_error;
    unique case (r_state)
      IDLE: begin
        if (w_start & (~r_done | rerun_en)) begin
          w_state   = FETCH;
          w_idx     = '0;
          w_err_idx = '0;
          w_tmo     = '0;
          w_retry   = '0;
          w_busy    = 1'b1;
          w_done    = 1'b0;
          w_error   = 1'b0;
        end
      end
      FETCH: w_state = CAPT;
      CAPT: begin
        w_addr = w_rd_addr;
        w_data = w_rd_data;
        w_tmo  = '0;
        w_retry = '0;
        w_state = w_mark ? DONE : WRITE;
      end
      WRITE: begin
        // An ack coinciding with the timeout still completes.
        if (bus.wr_ack) begin
          if (w_last) begin
            w_state = DONE;
          end else begin
            w_idx   = r_idx + IDX_W'(1);
            w_state = FETCH;
          end
        end else if (w_tmo_hit) begin
          if (r_retry < RTY_W'(MAX_RETRY)) begin
            w_state = HOLDOFF;
          end else begin
            w_state = ERR;
          end
        end else begin
          w_tmo = r_tmo + TMO_W'(1);
        end
      end
      HOLDOFF: begin
        w_retry = r_retry + RTY_W'(1);
        w_tmo   = '0;
        w_state = WRITE;
      end
      DONE: begin
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = IDLE;
      end
      ERR: begin
        w_busy    = 1'b0;
        w_error   = 1'b1;
        w_err_idx = r_idx;
        w_state   = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.tbl_rd   = (r_state == FETCH);
  assign bus.tbl_addr =
    (r_state == FETCH) ? r_idx : '0;
  assign bus.wr_req   = (r_state == WRITE);
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = r_data;

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign err_idx = r_err_idx;
endmodule

// File: tb/tb_poss_seq.sv
// Randomised bench for poss_seq against a
// transaction-level model of the write sequence.
module tb_poss_seq;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NE = 4;
  localparam int TO = 8;
  localparam int MR = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rerun_en = 1'b0;
  logic          busy;
  logic          done;
  logic          error;
  logic [IW-1:0] err_idx;

  poss_seq_if #(
    .ADDR_W(AW), .DATA_W(DW), .N_ENTRIES(NE)
  ) bus ();

  poss_seq #(
    .ADDR_W(AW), .DATA_W(DW), .N_ENTRIES(NE),
    .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rerun_en (rerun_en),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_idx  (err_idx)
  );

  always #5 clk = ~clk;

  logic [AW+DW-1:0] tbl [NE];
  int n_chk = 0;
  int n_fail = 0;

  // ack policy: 0 always, 1 random, 2 late, 3 never
  int            a_mode = 0;
  int            a_w = 0;
  int            a_gen = 0;
  logic [AW-1:0] a_tgt = '0;
  int            a_seen = 0;
  int            a_t = 0;
  bit            a_on = 0;
  bit            a_fin = 0;

  bit            q_req[$];
  bit            q_ack[$];
  bit            q_busy[$];
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];

  always @(posedge clk)
    bus.tbl_rdata <= bus.tbl_rd ? tbl[bus.tbl_addr]
                                : (AW+DW)'($urandom);

  always @(negedge clk) begin
    bit a;
    a = 1'b1;
    if (a_gen != a_seen) begin
      a_seen = a_gen;
      a_on = 0;
      a_fin = 0;
    end
    if (a_mode == 1) begin
      a = ($urandom_range(0, 3) != 0);
    end else if (a_mode >= 2 && !a_fin) begin
      if (!a_on && bus.wr_req &&
          bus.wr_addr == a_tgt) begin
        a_on = 1;
        a_t = 0;
      end
      if (a_on) begin
        a = (a_mode == 2) && (a_t >= a_w);
        a_t++;
        if (a && bus.wr_req) a_fin = 1;
      end
    end
    bus.wr_ack = a;
    q_req.push_back(bus.wr_req);
    q_ack.push_back(a);
    q_busy.push_back(busy);
    q_addr.push_back(bus.wr_addr);
    q_data.push_back(bus.wr_data);
  end

  task automatic chk(input string tg,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h",
               tg, got, exp);
    end
  endtask

  task automatic zero_chk(input string tg);
    chk({tg, "_flags"},
        {busy, done, error, bus.wr_req, bus.tbl_rd},
        0);
    chk({tg, "_eidx"}, err_idx, 0);
    chk({tg, "_waddr"}, bus.wr_addr, 0);
    chk({tg, "_wdata"}, bus.wr_data, 0);
  endtask

  task automatic analyse(input string tg, input int b0,
                         input int mode, input int tix,
                         input int w);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    logic [AW-1:0] ad, ra;
    logic [DW-1:0] rd;
    int ebusy, efail, f, nx, nfail, nbad, nbusy;
    int nmark, nunst, len;
    bit eerr;
    eerr = 0;
    efail = 0;
    ebusy = 1;
    for (int i = 0; i < NE; i++) begin
      ad = tbl[i][AW+DW-1 -: AW];
      ebusy += 2;
      if (ad == '1) break;
      if (mode >= 2 && i == tix) begin
        f = 0;
        if (mode == 3) f = MR + 1;
        else while (f*(TO+1) + TO - 1 < w) f++;
        if (f > MR) begin
          efail = MR + 1;
          ebusy += (MR + 1) * TO + MR;
          eerr = 1;
          break;
        end
        efail = f;
        ebusy += f * (TO + 1) + 1;
        if (w > f * (TO + 1)) ebusy += w - f * (TO + 1);
      end else begin
        ebusy += 1;
      end
      ea.push_back(ad);
      ed.push_back(tbl[i][DW-1:0]);
    end
    nx = 0; nfail = 0; nbad = 0; nbusy = 0;
    nmark = 0; nunst = 0; len = 0;
    ra = '0; rd = '0;
    for (int k = b0; k < q_req.size(); k++) begin
      if (q_busy[k]) nbusy++;
      if (q_req[k]) begin
        if (q_addr[k] == '1) nmark++;
        if (len == 0) begin
          ra = q_addr[k];
          rd = q_data[k];
        end else if (q_addr[k] !== ra ||
                     q_data[k] !== rd) begin
          nunst++;
        end
        len++;
        if (q_ack[k]) begin
          if (nx < ea.size()) begin
            chk($sformatf("%s_a%0d", tg, nx),
                q_addr[k], ea[nx]);
            chk($sformatf("%s_d%0d", tg, nx),
                q_data[k], ed[nx]);
          end
          nx++;
          len = 0;
        end
      end else if (len > 0) begin
        nfail++;
        if (len != TO) nbad++;
        len = 0;
      end
    end
    chk({tg, "_nwr"}, nx, ea.size());
    chk({tg, "_mark"}, nmark, 0);
    chk({tg, "_stable"}, nunst, 0);
    chk({tg, "_tlen"}, nbad, 0);
    if (mode != 1) begin
      chk({tg, "_retries"}, nfail, efail);
      chk({tg, "_busy"}, nbusy, ebusy);
    end
    chk({tg, "_err"}, error, eerr);
    chk({tg, "_done"}, done, !eerr);
    chk({tg, "_bsy0"}, busy, 0);
    if (eerr) chk({tg, "_eidx"}, err_idx, tix);
  endtask

  task automatic run(input string tg, input int mode,
                     input int tix, input int w,
                     input bit repulse);
    int b0;
    bit seen, ok;
    a_mode = mode;
    a_w = w;
    a_tgt = tbl[tix][AW+DW-1 -: AW];
    a_gen++;
    @(negedge clk);
    #1;
    b0 = q_req.size();
    start = 1'b1;
    seen = 0;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (repulse && c == 6) start = 1'b1;
      if (repulse && c == 9) start = 1'b0;
      if (busy) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    chk({tg, "_end"}, ok, 1);
    @(negedge clk);
    #1;
    analyse(tg, b0, mode, tix, w);
  endtask

  task automatic idle_chk(input string tg);
    int act;
    act = 0;
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (busy | bus.wr_req | bus.tbl_rd) act++;
    end
    chk({tg, "_act"}, act, 0);
    chk({tg, "_done"}, done, 1);
  endtask

  task automatic fixed_tbl();
    tbl[0] = {16'h0010, 16'hAAAA};
    tbl[1] = {16'h0011, 16'h5555};
    tbl[2] = {16'h0012, 16'h0001};
    tbl[3] = {16'h0013, 16'hFFFF};
  endtask

  initial begin
    bit found;
    fixed_tbl();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    zero_chk("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    rerun_en = 1'b0;
    run("t1", 0, 0, 0, 0);
    idle_chk("t5_norerun");
    rerun_en = 1'b1;
    run("t5_rerun", 0, 0, 0, 0);

    tbl[2][AW+DW-1 -: AW] = 16'hFFFF;
    run("t2", 0, 0, 0, 0);
    fixed_tbl();

    run("t3", 2, 1, 20, 0);
    run("t4", 3, 1, 0, 0);
    rerun_en = 1'b0;
    run("t4_restart", 0, 0, 0, 0);

    // reset while entry 2 is stuck in WRITE
    idle_chk("t6_pre");
    a_mode = 3;
    a_tgt = tbl[2][AW+DW-1 -: AW];
    a_gen++;
    rerun_en = 1'b1;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (bus.wr_req && bus.wr_addr == a_tgt) begin
        found = 1;
        break;
      end
    end
    start = 1'b0;
    chk("t6_reach", found, 1);
    rst = 1'b1;
    @(negedge clk);
    zero_chk("t6");
    rst = 1'b0;
    rerun_en = 1'b0;
    repeat (2) @(negedge clk);
    run("t6_run", 0, 0, 0, 0);

    rerun_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NE; i++) begin
        tbl[i][AW+DW-1 -: AW] =
          AW'(($urandom_range(0, 16'h1FFF) << 2) | i);
        tbl[i][DW-1:0] = DW'($urandom);
      end
      if (r > 0 && $urandom_range(0, 2) == 0)
        tbl[$urandom_range(0, NE-1)][AW+DW-1 -: AW] = '1;
      run($sformatf("rnd%0d", r), 1, 0, 0, r == 0);
    end

    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/poss_seq.md
Name: poss_seq

Overview:
Parametrised power-on self-set sequencer for CMD-3 modules. On a start pulse it walks a table of up to N_ENTRIES {address, data} pairs and issues each as a req/ack register write on the module's internal bus. It runs once per reset by default, supports optional re-run, per-write timeout with retry, early table termination, and reports busy/done/error status to slow control.

Parameters:
ADDR_W, 16, bus address width; all-ones address is the end marker
DATA_W, 16, bus data width
N_ENTRIES, 32, table depth; IDX_W = $clog2(N_ENTRIES), minimum 1
TIMEOUT, 255, cycles wr_req may stay high without wr_ack before the write is retried
MAX_RETRY, 3, retries per entry before error

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  asynchronous start request; a rising edge after synchronisation triggers a run
rerun_en  in  1  1 = a new start edge may re-run after done or error; 0 = one successful run per reset
tbl_rd  out  1  table read strobe
tbl_addr  out  IDX_W  table index
tbl_rdata  in  ADDR_W+DATA_W  {addr, data}; valid exactly 1 cycle after tbl_rd
wr_req  out  1  bus write request
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
wr_ack  in  1  write accepted; the transfer completes in any cycle with wr_req & wr_ack
busy  out  1  run in progress
done  out  1  sticky: last run completed successfully
error  out  1  sticky: last run aborted on retry exhaustion
err_idx  out  IDX_W  index of the failing entry; valid while error=1

Behaviour:
- Reset: every output is 0. The state machine is in IDLE, and the index, retry and timeout counters are 0. Synchroniser flops are cleared, so a start held high through reset produces no edge.
- Start: 2-flop synchroniser followed by an edge detector. start_edge = s2 & ~s3.
- IDLE: start_edge & (~done | rerun_en) → FETCH. On entry: idx=0, busy=1, done=0, error=0, retry=0.
  - start_edge while done=1 and rerun_en=0 is ignored.
  - start_edge while busy=1 is always ignored.
  - After an error, a new start is allowed regardless of rerun_en.
- FETCH: tbl_rd=1 and tbl_addr=idx for one cycle → CAPT.
- CAPT: register tbl_rdata into wr_addr/wr_data.
  - If addr is all ones → DONE; the end-marker entry is not written.
  - Otherwise → WRITE, with the timeout counter and retry counter cleared.
- WRITE: wr_req=1. wr_addr and wr_data stay stable until the transfer completes.
  - wr_req & wr_ack, with idx == N_ENTRIES-1 → DONE.
  - wr_req & wr_ack, otherwise → idx+1, then FETCH.
  - No ack and tmo == TIMEOUT-1 → HOLDOFF if retry < MAX_RETRY, else ERR.
  - Otherwise tmo increments.
  - An ack arriving in the same cycle as the timeout wins; the transfer completes.
- HOLDOFF: wr_req=0 for exactly one cycle, retry+1, tmo=0 → WRITE.
- DONE (1 cycle): busy=0, done=1 → IDLE.
- ERR (1 cycle): busy=0, error=1, err_idx=idx → IDLE.
- Minimum cost per entry is 3 cycles (FETCH, CAPT, WRITE with immediate ack).
  - A full N_ENTRIES run without the end marker and with zero-wait ack is busy for 3·N_ENTRIES+1 cycles.
- rst mid-run: wr_req drops the next cycle and the run is abandoned. done stays 0, so the next start performs a full run.
- Counter widths: tmo uses $clog2(TIMEOUT+1) bits, retry uses $clog2(MAX_RETRY+1) bits. Neither wraps; both are bounded by the compares above.
- Only IDLE, DONE and ERR are reachable outside a run. Illegal state encodings → IDLE.

Decomposition:
- poss_pkg holds:
  - the state enum poss_state_t {IDLE, FETCH, CAPT, WRITE, HOLDOFF, DONE, ERR}
  - the function is_end_mark(addr) returning &addr
  - the localparam DEFAULT_TIMEOUT
- Sub-module poss_start_sync holds the 2-flop synchroniser and rising-edge detect, with ports clk, rst, async_in, edge_out. It is reused by other slow-control blocks.

Test Plan:
1. N_ENTRIES=4, no end marker, table {0x0010:0xAAAA, 0x0011:0x5555, 0x0012:0x0001, 0x0013:0xFFFF}, wr_ack tied high, one start pulse.
   → Exactly 4 writes in order. busy high 13 cycles. done=1, error=0.
2. Entry 2 address = 0xFFFF.
   → Only entries 0 and 1 are written, then done=1. No wr_req with address 0xFFFF.
3. TIMEOUT=8, MAX_RETRY=2, wr_ack withheld on entry 1 for 20 cycles, then asserted.
   → Two HOLDOFF gaps on wr_req. Write completes on the third attempt. done=1.
4. wr_ack never asserted on entry 1.
   → 3 attempts of 8 cycles each, then error=1, err_idx=1, busy=0, done=0.
5. After done=1, second start with rerun_en=0, then third start with rerun_en=1.
   → Second start gives no bus activity. Third start repeats the full sequence.
6. rst during WRITE of entry 2, then start.
   → All outputs 0 the cycle after rst. The new run begins at index 0 and ends with done=1.
